spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter CS_SETUP, default 2, meaning cycles between SS assertion and eng_start.
REQ-002 SHALL have parameter CS_HOLD, default 2, meaning cycles between eng_done and SS deassertion.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning max cycles in WAIT before abort.
REQ-004 SHALL have port clk_cpu  in  1  single clock for all logic.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  2  per-requester transfer request (bit0 = requester 0).
REQ-007 SHALL have port req_ready  out  2  per-requester accept strobe.
REQ-008 SHALL have port req_wdata  in  64  {req1[31:0], req0[31:0]} transmit word.
REQ-009 SHALL have port req_bitrate  in  64  {req1, req0} SCK divider value.
REQ-010 SHALL have port req_cs  in  4  {req1[1:0], req0[1:0]} slave select index.
REQ-011 SHALL have port rsp_valid  out  2  one-cycle completion pulse per requester.
REQ-012 SHALL have port rsp_rdata  out  32  received word, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-014 SHALL have port eng_start  out  1  one-cycle start pulse to spi_control.
REQ-015 SHALL have port eng_wdata  out  32  word to spi_control SPI_DATA_OUT.
REQ-016 SHALL have port eng_bitrate  out  32  divider to spi_control SPI_BITRATE.
REQ-017 SHALL have port eng_done  in  1  completion from spi_control interrpt.
REQ-018 SHALL have port eng_rdata  in  32  spi_control SPI_DATA_IN.
REQ-019 SHALL have port ss_n  out  4  active-low one-hot slave selects.

Function
REQ-020 SHALL implement FSM IDLE -> SETUP -> START -> WAIT -> HOLD -> IDLE.
REQ-021 IDLE: when any req_valid is high, SHALL grant one requester, pulse its req_ready for 1 cycle, and latch wdata/bitrate/cs into internal registers.
REQ-022 Handshake: a transfer is accepted only on valid&ready; requesters hold valid until ready; valid dropped before ready SHALL not be granted.
REQ-023 Round-robin: when both are valid, SHALL grant the requester not granted last; a single valid requester SHALL be granted regardless.
REQ-024 SETUP: SHALL drive ss_n[cs]=0 and count CS_SETUP cycles, then enter START.
REQ-025 START: SHALL assert eng_start for exactly 1 cycle; eng_wdata/eng_bitrate SHALL be stable from SETUP entry to HOLD exit.
REQ-026 Latched bitrate 0 SHALL be driven as 1.
REQ-027 WAIT: on eng_done, SHALL capture eng_rdata, clear error, and enter HOLD.
REQ-028 WAIT: after TIMEOUT cycles without eng_done, SHALL set the error, capture 0, and enter HOLD.
REQ-029 If eng_done and the timeout occur in the same cycle, done SHALL win (err=0).
REQ-030 eng_done outside WAIT SHALL be ignored.
REQ-031 HOLD: SHALL keep ss_n asserted CS_HOLD cycles, then deassert ss_n, pulse rsp_valid[grant] with rsp_rdata/rsp_err for 1 cycle, record grant as last, and return to IDLE.
REQ-032 Latency: grant-to-eng_start SHALL be CS_SETUP+1 cycles; eng_done-to-rsp_valid SHALL be CS_HOLD+1 cycles.
REQ-033 ss_n SHALL be 4'b1111 in IDLE; at most one bit low at any time.
REQ-034 The earliest new grant SHALL occur the cycle after rsp_valid (no back-to-back overlap).

Reset
REQ-035 rst high SHALL asynchronously force IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, eng_start=0, eng_wdata=0, eng_bitrate=0, ss_n=4'b1111, counters=0, last-grant=1 (requester 0 wins first).
REQ-036 Reset mid-transfer SHALL abort with no rsp_valid; the aborted requester must re-request.

Structure
REQ-037 Package spi_arb_pkg SHALL hold the state enum, data width 32, requester count 2, and cs width 2.
REQ-038 The 2-way round-robin picker SHALL be sub-module spi_rr_arb (inputs valid[1:0], last; output grant).

Verification
REQ-039 Single request: req0 wdata=0x00000009, bitrate=2, cs=1 -> ss_n=4'b1101, eng_start 3 cycles after ready, eng_done with rdata=0xA5 -> rsp_valid[0] 3 cycles later, rsp_rdata=0xA5, err=0.
REQ-040 Contention: both valid from reset -> req0 served, then req1; both re-raise -> req1 skipped? no: req1 was last, so req0 served next; strict alternation over 4 transfers.
REQ-041 Timeout: TIMEOUT=16, eng_done never asserted -> rsp_valid after 16+CS_HOLD+1 WAIT/HOLD cycles, rsp_err=1, rsp_rdata=0.
REQ-042 Reset during WAIT: rst pulse -> ss_n=4'b1111 immediately, no rsp_valid, next request served normally.
REQ-043 Spurious eng_done in IDLE and SETUP -> no state change; eng_done coincident with timeout -> err=0.
REQ-044 bitrate=0 on req1 -> eng_bitrate=1.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared widths and FSM state type for the SPI arbiter
package spi_arb_pkg;

    localparam int DATA_W = 32;
    localparam int N_REQ  = 2;
    localparam int CS_W   = 2;
    localparam int N_SS   = 1 << CS_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/spi_rr_arb.sv
// rtl/spi_rr_arb.sv - two-way round-robin picker
module spi_rr_arb (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant
);

    // Both valid: take the one not served last; otherwise take whichever is valid.
    always_comb begin
        grant = valid[1];
        if (valid == 2'b11) begin
            grant = ~last;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - shares one spi_control engine between two requesters
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                  clk_cpu,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*DATA_W-1:0]   req_bitrate,
    input  logic [2*CS_W-1:0]     req_cs,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic [DATA_W-1:0]     eng_wdata,
    output logic [DATA_W-1:0]     eng_bitrate,
    input  logic                  eng_done,
    input  logic [DATA_W-1:0]     eng_rdata,
    output logic [N_SS-1:0]       ss_n
);

    // One counter is reused for setup, wait and hold; size it for the longest.
    localparam int CNT_MAX0 = (TIMEOUT > CS_SETUP) ? TIMEOUT : CS_SETUP;
    localparam int CNT_MAX  = (CNT_MAX0 > CS_HOLD) ? CNT_MAX0 : CS_HOLD;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    // Terminal counts; CS_SETUP, CS_HOLD and TIMEOUT are expected to be at least 1.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    arb_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_gnt;
    logic               r_last;
    logic [CS_W-1:0]    r_cs;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_bitrate;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic [N_REQ-1:0]   r_rsp_valid;

    logic               w_grant;
    logic               w_take;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [DATA_W-1:0]  w_sel_bitrate;
    logic [CS_W-1:0]    w_sel_cs;

    spi_rr_arb u_rr (
        .valid (req_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    // A grant is offered only in IDLE, never in the response cycle, never under reset.
    assign w_take = (r_state == ST_IDLE) && (r_rsp_valid == '0) && (req_valid != '0) && !rst;
    assign req_ready = w_take ? (2'b01 << w_grant) : 2'b00;

    assign w_sel_wdata   = w_grant ? req_wdata[2*DATA_W-1:DATA_W]   : req_wdata[DATA_W-1:0];
    assign w_sel_bitrate = w_grant ? req_bitrate[2*DATA_W-1:DATA_W] : req_bitrate[DATA_W-1:0];
    assign w_sel_cs      = w_grant ? req_cs[2*CS_W-1:CS_W]          : req_cs[CS_W-1:0];

    assign eng_start   = (r_state == ST_START);
    assign eng_wdata   = r_wdata;
    assign eng_bitrate = r_bitrate;
    assign ss_n        = (r_state == ST_IDLE) ? {N_SS{1'b1}} : ~(N_SS'(1) << r_cs);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;

    // Transfer sequencer: grant, select setup, engine start, wait/timeout, select hold.
    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_cs        <= '0;
            r_wdata     <= '0;
            r_bitrate   <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state   <= ST_SETUP;
                        r_cnt     <= '0;
                        r_gnt     <= w_grant;
                        r_cs      <= w_sel_cs;
                        r_wdata   <= w_sel_wdata;
                        r_bitrate <= (w_sel_bitrate == '0) ? DATA_W'(1) : w_sel_bitrate;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    // Done is checked first so it wins over a coincident timeout.
                    if (eng_done) begin
                        r_rdata <= eng_rdata;
                        r_err   <= 1'b0;
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == WAIT_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_rsp_valid <= 2'b01 << r_gnt;
                        r_last      <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - randomized self-checking bench for spi_arbiter
module tb_spi_arbiter;

    localparam int S = 2;
    localparam int H = 2;
    localparam int T = 16;

    logic        clk_cpu = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_wdata;
    logic [63:0] req_bitrate;
    logic [3:0]  req_cs;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        eng_start;
    logic [31:0] eng_wdata;
    logic [31:0] eng_bitrate;
    logic        eng_done;
    logic [31:0] eng_rdata;
    logic [3:0]  ss_n;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: who was served last, and each requester's current request.
    logic        m_last;
    logic [31:0] wd [2];
    logic [31:0] br [2];
    logic [1:0]  csel [2];

    always #5 clk_cpu = ~clk_cpu;

    spi_arbiter #(.CS_SETUP(S), .CS_HOLD(H), .TIMEOUT(T)) dut (
        .clk_cpu     (clk_cpu),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wdata   (req_wdata),
        .req_bitrate (req_bitrate),
        .req_cs      (req_cs),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .eng_start   (eng_start),
        .eng_wdata   (eng_wdata),
        .eng_bitrate (eng_bitrate),
        .eng_done    (eng_done),
        .eng_rdata   (eng_rdata),
        .ss_n        (ss_n)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 2; i++) begin
            wd[i]   = $urandom;
            br[i]   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            csel[i] = 2'($urandom_range(0, 3));
        end
    endtask

    // mode 0: engine done d cycles into WAIT; 1: never done (timeout); 2: reset d cycles into WAIT
    task automatic do_xfer(input logic [1:0] mask, input int mode, input int d,
                           input logic spur, input logic [31:0] rd);
        int          g;
        int          gap;
        int          k_ev;
        int          k_rsp;
        logic [3:0]  ess;
        logic [31:0] ebr;
        logic [31:0] erd;
        logic        eerr;

        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk_cpu); #1;
            req_valid = 2'b00;
            eng_done  = 1'($urandom_range(0, 1));
            eng_rdata = $urandom;
            @(negedge clk_cpu);
            chk("idle_ss", ss_n, 4'hF);
            chk("idle_rsp", rsp_valid, 2'b00);
        end

        g    = (mask == 2'b11) ? (m_last ? 0 : 1) : (mask[0] ? 0 : 1);
        ess  = 4'hF;
        ess[csel[g]] = 1'b0;
        ebr  = (br[g] == 32'd0) ? 32'd1 : br[g];
        k_ev = S + 2 + d;
        k_rsp = (mode == 1) ? (S + T + H + 2) : (k_ev + H + 1);
        erd  = (mode == 1) ? 32'd0 : rd;
        eerr = (mode == 1);

        @(posedge clk_cpu); #1;
        req_valid   = mask;
        req_wdata   = {wd[1], wd[0]};
        req_bitrate = {br[1], br[0]};
        req_cs      = {csel[1], csel[0]};
        eng_done    = spur;
        eng_rdata   = $urandom;
        @(negedge clk_cpu);
        chk("grant", req_ready, 64'(2'b01 << g));

        for (int k = 1; k <= k_rsp; k++) begin
            @(posedge clk_cpu); #1;
            req_valid = (k == k_rsp) ? 2'b11 : 2'b00;
            eng_done  = (spur && k == 1) || (mode == 0 && k == k_ev);
            eng_rdata = (mode == 0 && k == k_ev) ? rd : $urandom;
            if (mode == 2 && k == k_ev) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_ss", ss_n, 4'hF);
                chk("rst_start", eng_start, 1'b0);
                #1 rst = 1'b0;
                m_last = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk_cpu);
                    chk("rst_rsp", rsp_valid, 2'b00);
                    chk("rst_ss_hold", ss_n, 4'hF);
                    chk("rst_rdata", rsp_rdata, 32'd0);
                    chk("rst_wdata", eng_wdata, 32'd0);
                end
                return;
            end
            @(negedge clk_cpu);
            chk("busy_ready", req_ready, 2'b00);
            chk("eng_start", eng_start, (k == S + 1));
            chk("rsp_valid", rsp_valid, (k == k_rsp) ? 64'(2'b01 << g) : 64'd0);
            if (k < k_rsp) begin
                chk("ss_n", ss_n, ess);
                chk("eng_wdata", eng_wdata, wd[g]);
                chk("eng_bitrate", eng_bitrate, ebr);
            end else begin
                chk("ss_release", ss_n, 4'hF);
                chk("rsp_rdata", rsp_rdata, erd);
                chk("rsp_err", rsp_err, eerr);
            end
        end
        m_last = g[0];
    endtask

    initial begin
        int r;
        rst         = 1'b1;
        req_valid   = 2'b11;
        req_wdata   = '0;
        req_bitrate = '0;
        req_cs      = '0;
        eng_done    = 1'b0;
        eng_rdata   = '0;
        m_last      = 1'b1;
        repeat (2) @(negedge clk_cpu);
        chk("rst_ready0", req_ready, 2'b00);
        chk("rst_rsp0", rsp_valid, 2'b00);
        chk("rst_rdata0", rsp_rdata, 32'd0);
        chk("rst_err0", rsp_err, 1'b0);
        chk("rst_start0", eng_start, 1'b0);
        chk("rst_wdata0", eng_wdata, 32'd0);
        chk("rst_bitrate0", eng_bitrate, 32'd0);
        chk("rst_ss0", ss_n, 4'hF);
        @(posedge clk_cpu); #1;
        rst       = 1'b0;
        req_valid = 2'b00;

        // Single request from requester 0, cs=1, bitrate 2, engine returns 0xA5.
        rand_data();
        wd[0] = 32'h9; br[0] = 32'd2; csel[0] = 2'd1;
        do_xfer(2'b01, 0, 3, 1'b0, 32'hA5);

        // Contention: both always valid, strict alternation.
        for (int i = 0; i < 4; i++) begin
            rand_data();
            do_xfer(2'b11, 0, $urandom_range(0, 4), 1'b0, $urandom);
        end

        // Bitrate 0 on requester 1.
        rand_data();
        br[1] = 32'd0;
        do_xfer(2'b10, 0, 1, 1'b0, $urandom);

        // Timeout, done coincident with timeout, spurious done in IDLE/SETUP.
        rand_data();
        do_xfer(2'b01, 1, 0, 1'b0, 32'h0);
        rand_data();
        do_xfer(2'b10, 0, T - 1, 1'b0, $urandom);
        rand_data();
        do_xfer(2'b11, 0, 2, 1'b1, $urandom);

        // Reset during WAIT, then a normal transfer.
        rand_data();
        do_xfer(2'b10, 2, 3, 1'b0, 32'h0);
        rand_data();
        do_xfer(2'b11, 0, 0, 1'b0, $urandom);

        // Random mix.
        for (int i = 0; i < 40; i++) begin
            rand_data();
            r = $urandom_range(0, 9);
            if (r <= 5)
                do_xfer(2'($urandom_range(1, 3)), 0, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom);
            else if (r == 6)
                do_xfer(2'($urandom_range(1, 3)), 0, T - 1, 1'($urandom_range(0, 1)), $urandom);
            else if (r == 7)
                do_xfer(2'($urandom_range(1, 3)), 1, 0, 1'($urandom_range(0, 1)), 32'h0);
            else
                do_xfer(2'($urandom_range(1, 3)), 2, $urandom_range(0, T - 1), 1'($urandom_range(0, 1)), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
